// File: rtl/md_issue_ctrl.sv
// E-stage to multiply/divide issue buffer: captures MD ops, pulses start, stalls on pending results.
// Optional MD_PERF_CNT_EN adds perf_md_issued / perf_stall_cyc event counters.
module md_issue_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned OPT_W  = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              e_md_valid,
    input  logic [OPT_W-1:0]  e_md_opt,
    input  logic [DATA_W-1:0] e_rs,
    input  logic [DATA_W-1:0] e_rt,
    input  logic              e_mf_valid,
    input  logic              e_mf_sel,
    input  logic              md_busy,
    input  logic [DATA_W-1:0] md_hi,
    input  logic [DATA_W-1:0] md_lo,
    output logic              md_start,
    output logic [OPT_W-1:0]  md_opt,
    output logic [DATA_W-1:0] md_v1,
    output logic [DATA_W-1:0] md_v2,
`ifdef MD_PERF_CNT_EN
    output logic [31:0]       perf_md_issued,
    output logic [31:0]       perf_stall_cyc,
`endif
    output logic              stall,
    output logic [DATA_W-1:0] mf_data
);

    // Highest legal opcode (mtlo); 110/111 are treated as NOPs.
    localparam logic [OPT_W-1:0] OPT_MAX = OPT_W'(5);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    state_t state;
    logic   free;
    logic   legal;
    logic   accept;

    always_comb begin
        free    = (state == IDLE) || ((state == WAIT) && !md_busy);
        legal   = (e_md_opt <= OPT_MAX);
        accept  = free && e_md_valid && legal;
        stall   = ((e_md_valid && legal) || e_mf_valid) && !free;
        mf_data = e_mf_sel ? md_lo : md_hi;
    end

    // State, start pulse and operand buffer; buffer only moves on capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            md_start <= 1'b0;
            md_opt   <= '0;
            md_v1    <= '0;
            md_v2    <= '0;
        end else begin
            md_start <= accept;
            if (accept) begin
                md_opt <= e_md_opt;
                md_v1  <= e_rs;
                md_v2  <= e_rt;
            end
            case (state)
                IDLE:    state <= accept ? ISSUE : IDLE;
                ISSUE:   state <= WAIT;
                WAIT:    state <= md_busy ? WAIT : (accept ? ISSUE : IDLE);
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MD_PERF_CNT_EN
    // Free-running event counters, wrapping naturally at 2^32.
    always_ff @(posedge clk) begin
        if (reset) begin
            perf_md_issued <= '0;
            perf_stall_cyc <= '0;
        end else begin
            perf_md_issued <= perf_md_issued + 32'(md_start);
            perf_stall_cyc <= perf_stall_cyc + 32'(stall);
        end
    end
`endif

endmodule
